// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, chip-enable levels, reset PC,
// BRANCH opcode, queue entry layout and the B-type immediate decoder.
package inst_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [INST_ADDR_W-1:0] RESET_PC   = '0;
    localparam logic [6:0]             OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
        logic                   pred;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] b_imm(input logic [INST_W-1:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_queue.sv
// Two-entry fetch queue (fetch_queue): entry 0 is always the head, entry 1 the tail.
module fetch_queue
    import inst_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  logic         i_pop,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [1:0]   o_count
);

    fetch_entry_t r_ent0;
    fetch_entry_t r_ent1;
    logic [1:0]   r_count;

    // Push into a full queue only happens together with a pop (gated upstream).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_ent0 <= i_data;
                    else                 r_ent1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_data;
                    end else begin
                        r_ent0 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_ent0;
    assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, ROM interface and 2-entry queue toward decode.
// Optional static backward-taken predictor enabled by macro STATIC_BTFN_PREDICT_EN.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic                   rom_ce_o,
    output logic [INST_ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0]      rom_inst_i,
    input  logic                   jump_i,
    input  logic [INST_ADDR_W-1:0] jump_addr_i,
    output logic                   if_valid_o,
    input  logic                   id_ready_i,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   if_pred_taken_o
);

    logic [INST_ADDR_W-1:0] r_pc;
    logic [INST_ADDR_W-1:0] w_next_pc;
    logic [INST_ADDR_W-1:0] w_jump_target;
    logic [1:0]             w_count;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_pred;
    fetch_entry_t           w_head;
    fetch_entry_t           w_new;

    assign if_valid_o = (w_count != 2'd0) && !jump_i;
    assign w_pop      = if_valid_o && id_ready_i;
    assign rom_ce_o   = (rst && !jump_i && ((w_count != 2'd2) || w_pop)) ? CHIP_ENABLE : CHIP_DISABLE;
    assign w_push     = (rom_ce_o == CHIP_ENABLE);
    assign rom_addr_o = r_pc;

    assign w_jump_target = jump_addr_i & ~32'h3;

`ifdef STATIC_BTFN_PREDICT_EN
    assign w_pred    = (rom_inst_i[6:0] == OPC_BRANCH) && rom_inst_i[31];
    // Target is re-aligned so the ROM address stays word-aligned.
    assign w_next_pc = w_pred ? ((r_pc + b_imm(rom_inst_i)) & ~32'h3) : (r_pc + 32'd4);
`else
    assign w_pred    = 1'b0;
    assign w_next_pc = r_pc + 32'd4;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (jump_i) begin
            r_pc <= w_jump_target;
        end else if (w_push) begin
            r_pc <= w_next_pc;
        end
    end

    assign w_new = '{pc: r_pc, inst: rom_inst_i, pred: w_pred};

    fetch_queue u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_flush (jump_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_new),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign if_pc_o         = w_head.pc;
    assign if_inst_o       = w_head.inst;
    assign if_pred_taken_o = w_head.pred;

endmodule
